// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Read-side master for an 8 x WIDTH register file. A start pulse walks
//   R0..R7 in order: the register's one-hot read select is driven, held
//   for SETTLE cycles, the word is captured, and it is then offered on a
//   valid/ready stream together with its register index. A one-cycle
//   done pulse follows acceptance of the last beat.
//
// Parameters
//   WIDTH   data word width (must match the register file)
//   SETTLE  cycles rd_sel is held before rd_data is sampled (1..4)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin a dump (sampled only while idle)
//   abort      terminate a dump; idle on the next edge
//   rd_sel     one-hot read select to the register file mux
//   rd_data    word returned by the register file mux
//   out_data   captured word
//   out_idx    register index of out_data
//   out_valid  out_data/out_idx valid
//   out_ready  consumer accepts the beat when out_valid & out_ready
//   out_cksum  (DUMP_CKSUM_EN only) marks the trailing checksum beat
//   busy       high whenever not idle
//   done       one-cycle pulse after the final beat is accepted
//
// Build option
//   DUMP_CKSUM_EN  when defined, an XOR of all captured words is sent as
//                  a ninth beat (out_idx = 0, out_cksum = 1) before done.

module regfile_dump_reader #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [7:0]       rd_sel,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_idx,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DUMP_CKSUM_EN
    output logic             out_cksum,
`endif
    output logic             busy,
    output logic             done
);

`ifdef DUMP_CKSUM_EN
    typedef enum logic [2:0] {IDLE, SEL, CAP, OUT, DONE, CKS} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEL, CAP, OUT, DONE} state_t;
`endif

    // Settle counter runs 0..SETTLE-1, so two bits cover SETTLE up to 4.
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       idx;
    logic [1:0]       cnt;
`ifdef DUMP_CKSUM_EN
    logic [WIDTH-1:0] acc;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        rd_sel    = '0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
`ifdef DUMP_CKSUM_EN
        out_cksum = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SEL;
                end
            end
            SEL: begin
                rd_sel = 8'b1 << idx;
                if (cnt == SETTLE_LAST) begin
                    state_nxt = CAP;
                end
            end
            CAP: begin
                rd_sel    = 8'b1 << idx;
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx != 3'd7) begin
                        state_nxt = SEL;
                    end else begin
`ifdef DUMP_CKSUM_EN
                        state_nxt = CKS;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
`ifdef DUMP_CKSUM_EN
            CKS: begin
                out_valid = 1'b1;
                out_cksum = 1'b1;
                if (out_ready) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides any pending transition, including a beat
        // acceptance in the same cycle.
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // Datapath: register index, settle counter, captured beat, checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_idx  <= '0;
`ifdef DUMP_CKSUM_EN
            acc      <= '0;
`endif
        end else if (abort && (state != IDLE)) begin
            idx <= '0;
            cnt <= '0;
`ifdef DUMP_CKSUM_EN
            acc <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
                        cnt <= '0;
`ifdef DUMP_CKSUM_EN
                        acc <= '0;
`endif
                    end
                end
                SEL: begin
                    if (cnt != SETTLE_LAST) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                CAP: begin
                    out_data <= rd_data;
                    out_idx  <= idx;
`ifdef DUMP_CKSUM_EN
                    acc      <= acc ^ rd_data;
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        if (idx != 3'd7) begin
                            idx <= idx + 3'd1;
                            cnt <= '0;
                        end
`ifdef DUMP_CKSUM_EN
                        else begin
                            // acc already includes R7 (folded in at CAP)
                            out_data <= acc;
                            out_idx  <= '0;
                        end
`endif
                    end
                end
                DONE: begin
                    idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//   Self-checking bench for regfile_dump_reader. A behavioural register
//   file answers the one-hot select; a scoreboard built from the register
//   contents checks every accepted beat, hold stability during stalls,
//   latencies, abort, asynchronous reset and ignored start pulses.

module tb_regfile_dump_reader;

    localparam int SETTLE   = 1;
    localparam int BEAT_CYC = SETTLE + 2;
`ifdef DUMP_CKSUM_EN
    localparam int NBEATS    = 9;
    localparam int DONE_BASE = 8 * BEAT_CYC + 2;
`else
    localparam int NBEATS    = 8;
    localparam int DONE_BASE = 8 * BEAT_CYC + 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  rd_sel;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic [2:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef DUMP_CKSUM_EN
    logic        out_cksum;
`endif

    logic [15:0] regs [8];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int pat;            // 0: Ri = 1<<i, 1: random words
        int stall_beat;     // beat number held off (-1: none)
        int stall_len;      // cycles out_ready held low on that beat
        int restart_at;     // cycle after start to pulse start again (0: never)
        bit start_on_done;  // pulse start in the done cycle
        int exp_stalls;     // expected extra cycles from the stall
    } vec_t;

    vec_t vecs [5];

    regfile_dump_reader #(
        .WIDTH  (16),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DUMP_CKSUM_EN
        .out_cksum (out_cksum),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural register file mux: non-one-hot selects return a marker.
    always_comb begin
        rd_data = 16'hDEAD;
        for (int i = 0; i < 8; i++) begin
            if (rd_sel == (8'h01 << i)) begin
                rd_data = regs[i];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event not seen within bound at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int pat);
        for (int i = 0; i < 8; i++) begin
            regs[i] = (pat == 0) ? (16'(1) << i) : 16'($urandom);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_sel"},    rd_sel,    0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_idx"},   out_idx,   0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
    endtask

    // Runs one full dump from a start pulse and scores every beat.
    task automatic run_dump(input int stall_beat, input int stall_len, input bit rand_ready,
                            input int restart_at, input bit start_on_done,
                            output int first_lat, output int done_lat,
                            output int beats, output int stalls);
        int          k;
        int          left;
        bit          holding;
        bit          finished;
        logic [15:0] hd;
        logic [2:0]  hi;
        logic [15:0] cks;
        cks = '0;
        for (int i = 0; i < 8; i++) cks ^= regs[i];
        first_lat = -1;
        done_lat  = -1;
        beats     = 0;
        stalls    = 0;
        left      = stall_len;
        holding   = 1'b0;
        finished  = 1'b0;
        hd        = '0;
        hi        = '0;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        k     = 1;
        while (!finished && k < 1000) begin
            start = (k == restart_at);
            chk("busy_in_dump", busy, 1);
            chk("rd_sel_onehot", (rd_sel == 8'h00) || (rd_sel == (8'h01 << beats)), 1);
            if (beats == 2 && rd_sel != 8'h00) chk("rd_sel_r2", rd_sel, 8'h04);
            if (holding) chk("valid_held", out_valid, 1);
            if (done) begin
                done_lat = k;
                finished = 1'b1;
            end else if (out_valid) begin
                if (first_lat < 0) first_lat = k;
                if (holding) begin
                    chk("hold_data", out_data, hd);
                    chk("hold_idx", out_idx, hi);
                end
                if (beats == stall_beat && left > 0) begin
                    out_ready = 1'b0;
                    left--;
                end else begin
                    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) begin
                    if (beats < 8) begin
                        chk("beat_idx", out_idx, beats);
                        chk("beat_data", out_data, regs[beats]);
`ifdef DUMP_CKSUM_EN
                        chk("beat_cksum_flag", out_cksum, 0);
`endif
                    end else begin
                        chk("cksum_idx", out_idx, 0);
                        chk("cksum_data", out_data, cks);
`ifdef DUMP_CKSUM_EN
                        chk("cksum_flag", out_cksum, 1);
`endif
                    end
                    beats++;
                    holding = 1'b0;
                end else begin
                    stalls++;
                    holding = 1'b1;
                    hd      = out_data;
                    hi      = out_idx;
                end
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!finished) begin
                step();
                k++;
            end
        end
        start = 1'b0;
        if (!finished) begin
            fail_now("dump_timeout");
        end else begin
            start = start_on_done;
            step();
            start = 1'b0;
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
            chk("rd_sel_idle", rd_sel, 0);
            step();
            chk("no_restart_busy", busy, 0);
            chk("no_restart_done", done, 0);
        end
        out_ready = 1'b1;
    endtask

    task automatic dump_and_check(input int pat, input int stall_beat, input int stall_len,
                                  input bit rand_ready, input int restart_at,
                                  input bit start_on_done, input int exp_stalls);
        int first_lat;
        int done_lat;
        int beats;
        int stalls;
        load(pat);
        run_dump(stall_beat, stall_len, rand_ready, restart_at, start_on_done,
                 first_lat, done_lat, beats, stalls);
        chk("beat_count", beats, NBEATS);
        chk("first_valid_latency", first_lat, BEAT_CYC);
        chk("done_latency", done_lat, DONE_BASE + ((exp_stalls < 0) ? stalls : exp_stalls));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        load(0);

        vecs[0] = '{pat: 0, stall_beat: -1, stall_len: 0, restart_at: 0,  start_on_done: 1'b0, exp_stalls: 0};
        vecs[1] = '{pat: 0, stall_beat: 3,  stall_len: 5, restart_at: 0,  start_on_done: 1'b0, exp_stalls: 5};
        vecs[2] = '{pat: 1, stall_beat: 0,  stall_len: 2, restart_at: 5,  start_on_done: 1'b1, exp_stalls: 2};
        vecs[3] = '{pat: 1, stall_beat: 7,  stall_len: 1, restart_at: 10, start_on_done: 1'b0, exp_stalls: 1};
        vecs[4] = '{pat: 0, stall_beat: 2,  stall_len: 3, restart_at: 2,  start_on_done: 1'b1, exp_stalls: 3};

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_reset_outputs("idle");

        for (int v = 0; v < 5; v++) begin
            dump_and_check(vecs[v].pat, vecs[v].stall_beat, vecs[v].stall_len, 1'b0,
                           vecs[v].restart_at, vecs[v].start_on_done, vecs[v].exp_stalls);
        end

        // Abort while beat 5 is on offer, with out_ready also high.
        load(0);
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        k     = 0;
        while (k < 200 && !(out_valid && out_idx == 3'd5)) begin
            step();
            k++;
        end
        if (!(out_valid && out_idx == 3'd5)) begin
            fail_now("abort_reach_idx5");
        end else begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_rd_sel", rd_sel, 0);
            repeat (4) begin
                step();
                chk("abort_no_done", done, 0);
                chk("abort_stays_idle", busy, 0);
            end
        end
        dump_and_check(0, -1, 0, 1'b0, 0, 1'b0, 0);

        // Asynchronous reset while R2 is selected, after an ignored start.
        load(0);
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        k     = 0;
        while (k < 100 && rd_sel != 8'h04) begin
            step();
            k++;
        end
        if (rd_sel != 8'h04) begin
            fail_now("reset_reach_r2");
        end else begin
            #2 reset = 1'b1;
            #1;
            chk_reset_outputs("mid_reset");
            @(negedge clk);
            reset = 1'b0;
            repeat (6) begin
                step();
                chk("post_reset_valid", out_valid, 0);
                chk("post_reset_busy", busy, 0);
            end
        end

        // Randomized data and consumer backpressure.
        for (int r = 0; r < 6; r++) begin
            dump_and_check(1, -1, 0, 1'b1, int'($urandom_range(0, 20)),
                           1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
